// File: rtl/fft_replica_buf.sv
`timescale 1ns/1ps
// fft_replica_buf: captures one FFT output frame into a local RAM and replays it
// REPL times, one sample per cycle, to the frequency-domain conv engine.
module fft_replica_buf #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 64,
  parameter  int REPL  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int RW    = (REPL > 1) ? $clog2(REPL) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fftvalid,
  input  logic [DW-1:0] fftdata,
  input  logic          fftlast,
  output logic          fftready,
  output logic          replicaready,
  input  logic          convstart,
  output logic          outvalid,
  output logic [DW-1:0] outdata,
  output logic          outlast,
  input  logic          outready,
  output logic [RW-1:0] repl_idx,
  output logic          done,
  output logic          err
);

  // Frame length needs one more bit than an address to hold DEPTH itself.
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_READY,
    S_REPLAY,
    S_DONE
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_cnt;
  logic [LW-1:0] len;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_nxt;
  logic [AW-1:0] rd_sel;
  logic [RW-1:0] repl_nxt;

  logic          accept;
  logic          wr_full;
  logic          frame_end;
  logic          frame_err;
  logic          xfer;
  logic          wrap;
  logic          last_nxt;
  logic          rd_en;
  logic          fftready_d;

  // ---------------------------------------------------------------------------
  // Ingest side: IDLE behaves as FILL with wr_cnt still at 0.
  // ---------------------------------------------------------------------------
  assign accept    = fftvalid && fftready;
  assign wr_full   = (wr_cnt == AW'(DEPTH - 1));
  assign frame_end = fftlast || wr_full;
  // A frame is good only when fftlast arrives exactly on the final RAM slot.
  assign frame_err = !(fftlast && wr_full);

  // ---------------------------------------------------------------------------
  // Replay side: rd_addr/repl_idx describe the sample currently on outdata.
  // ---------------------------------------------------------------------------
  assign xfer     = outvalid && outready;
  assign wrap     = (LW'(rd_addr) == (len - LW'(1)));
  assign rd_nxt   = wrap ? '0 : rd_addr + AW'(1);
  assign repl_nxt = wrap ? repl_idx + RW'(1) : repl_idx;
  assign last_nxt = (LW'(rd_nxt) == (len - LW'(1))) && (repl_nxt == RW'(REPL - 1));

  assign rd_en  = ((state == S_READY) && convstart) ||
                  ((state == S_REPLAY) && xfer && !outlast);
  assign rd_sel = (state == S_READY) ? '0 : rd_nxt;

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples the
  // pre-edge value of its peers, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_FILL: if (accept)            next_state = frame_end ? S_READY : S_FILL;
      S_READY:        if (convstart)         next_state = S_REPLAY;
      S_REPLAY:       if (xfer && outlast)   next_state = S_DONE;
      S_DONE:                                next_state = S_IDLE;
      default:                               next_state = S_IDLE;
    endcase
  end

  always_comb begin
    replicaready = 1'b0;
    done         = 1'b0;
    fftready_d   = 1'b0;
    case (state)
      S_READY, S_REPLAY: replicaready = 1'b1;
      S_DONE:            done         = 1'b1;
      default: ;
    endcase
    // fftready is registered so it reads 0 straight out of reset.
    fftready_d = (next_state == S_IDLE) || (next_state == S_FILL);
  end

  // ---------------------------------------------------------------------------
  // Counters, flags and replay handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fftready <= 1'b0;
      wr_cnt   <= '0;
      len      <= '0;
      rd_addr  <= '0;
      repl_idx <= '0;
      outvalid <= 1'b0;
      outlast  <= 1'b0;
      err      <= 1'b0;
    end else begin
      fftready <= fftready_d;
      case (state)
        S_IDLE, S_FILL: begin
          if (accept) begin
            if (frame_end) begin
              len    <= LW'(wr_cnt) + LW'(1);
              wr_cnt <= '0;
              if (frame_err) err <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + AW'(1);
            end
          end
        end
        S_READY: begin
          if (convstart) begin
            rd_addr  <= '0;
            repl_idx <= '0;
            outvalid <= 1'b1;
            outlast  <= (len == LW'(1)) && (REPL == 1);
          end
        end
        S_REPLAY: begin
          // Outputs only move on a transfer, so a stall holds them stable.
          if (xfer) begin
            if (outlast) begin
              outvalid <= 1'b0;
              outlast  <= 1'b0;
            end else begin
              rd_addr  <= rd_nxt;
              repl_idx <= repl_nxt;
              outlast  <= last_nxt;
            end
          end
        end
        S_DONE: begin
          wr_cnt   <= '0;
          len      <= '0;
          rd_addr  <= '0;
          repl_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame RAM: synchronous write, registered read into outdata
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array has no reset; stale contents are never observable
  // because replay only reads addresses below a freshly captured len.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt] <= fftdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        outdata <= '0;
    else if (rd_en) outdata <= mem[rd_sel];
  end

endmodule

// File: tb/tb_fft_replica_buf.sv
`timescale 1ns/1ps
// tb_fft_replica_buf: directed scenarios for frame capture, replay, backpressure,
// frame-length errors, ignored convstart and asynchronous reset.
module tb_fft_replica_buf;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int REPL  = 8;
  localparam int RW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          fftvalid;
  logic [DW-1:0] fftdata;
  logic          fftlast;
  logic          fftready;
  logic          replicaready;
  logic          convstart;
  logic          outvalid;
  logic [DW-1:0] outdata;
  logic          outlast;
  logic          outready;
  logic [RW-1:0] repl_idx;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  fft_replica_buf #(.DW(DW), .DEPTH(DEPTH), .REPL(REPL)) dut (
    .clk          (clk),
    .rst          (rst),
    .fftvalid     (fftvalid),
    .fftdata      (fftdata),
    .fftlast      (fftlast),
    .fftready     (fftready),
    .replicaready (replicaready),
    .convstart    (convstart),
    .outvalid     (outvalid),
    .outdata      (outdata),
    .outlast      (outlast),
    .outready     (outready),
    .repl_idx     (repl_idx),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Push one frame: data = base+i, fftlast on beat last_at (-1 = never),
  // convstart pulsed together with beat cs_beat (-1 = never).
  task automatic send_frame(input logic [31:0] base, input int n, input int last_at,
                            input int cs_beat, input logic exp_err);
    int w = 0;
    while (fftready !== 1'b1 && w < 10) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (fftready !== 1'b1) begin
      errors++;
      $display("FAIL frame_ready_wait: fftready=%b required 1", fftready);
    end
    for (int i = 0; i < n; i++) begin
      fftvalid  = 1'b1;
      fftdata   = base + 32'(i);
      fftlast   = (i == last_at);
      convstart = (i == cs_beat);
      if (i == n - 1) begin
        checks++;
        if (replicaready !== 1'b0) begin
          errors++;
          $display("FAIL replicaready_early: replicaready=%b required 0", replicaready);
        end
      end
      @(posedge clk); #1;
      convstart = 1'b0;
    end
    fftvalid = 1'b0;
    fftlast  = 1'b0;
    fftdata  = '0;
    checks++;
    if (replicaready !== 1'b1 || fftready !== 1'b0 || err !== exp_err || outvalid !== 1'b0) begin
      errors++;
      $display("FAIL frame_stored: replicaready=%b fftready=%b err=%b outvalid=%b required 1 0 %b 0",
               replicaready, fftready, err, outvalid, exp_err);
    end
  endtask

  // Issue convstart and consume the replay; abort_at >= 0 asserts rst before that beat.
  task automatic replay(input logic [31:0] base, input int len, input bit toggle,
                        input int abort_at);
    int            total = len * REPL;
    int            k     = 0;
    int            cyc   = 0;
    bit            aborted = 1'b0;
    logic [31:0]   exp_d;
    logic [RW-1:0] exp_r;
    logic          exp_l;
    convstart = 1'b1;
    @(posedge clk); #1;
    convstart = 1'b0;
    checks++;
    if (outvalid !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: outvalid=%b required 1 one cycle after convstart", outvalid);
    end
    while (k < total && cyc < 2 * total + 10) begin
      if (abort_at >= 0 && k == abort_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({outvalid, outlast, replicaready, done, err, fftready} !== 6'b0 ||
            outdata !== '0 || repl_idx !== '0) begin
          errors++;
          $display("FAIL async_reset: vld=%b last=%b rrdy=%b done=%b err=%b frdy=%b data=%h idx=%0d required all 0",
                   outvalid, outlast, replicaready, done, err, fftready, outdata, repl_idx);
        end
        aborted = 1'b1;
        break;
      end
      outready = toggle ? (cyc % 2 == 0) : 1'b1;
      exp_d = base + 32'(k % len);
      exp_r = RW'(k / len);
      exp_l = (k == total - 1);
      checks++;
      if (outvalid !== 1'b1 || outdata !== exp_d || repl_idx !== exp_r || outlast !== exp_l) begin
        errors++;
        $display("FAIL replay_beat %0d: vld=%b data=%h idx=%0d last=%b required 1 %h %0d %b",
                 k, outvalid, outdata, repl_idx, outlast, exp_d, exp_r, exp_l);
      end
      if (outready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    outready = 1'b0;
    if (!aborted) begin
      checks++;
      if (k != total) begin
        errors++;
        $display("FAIL replay_count: transfers=%0d required %0d (cycle budget expired)", k, total);
      end
      if (!toggle) begin
        checks++;
        if (cyc != total) begin
          errors++;
          $display("FAIL replay_duration: cycles=%0d required %0d", cyc, total);
        end
      end
      checks++;
      if (done !== 1'b1 || outvalid !== 1'b0 || replicaready !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: done=%b outvalid=%b replicaready=%b required 1 0 0",
                 done, outvalid, replicaready);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || fftready !== 1'b1 || outlast !== 1'b0) begin
        errors++;
        $display("FAIL back_to_idle: done=%b fftready=%b outlast=%b required 0 1 0",
                 done, fftready, outlast);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    fftvalid  = 1'b0;
    fftdata   = '0;
    fftlast   = 1'b0;
    convstart = 1'b0;
    outready  = 1'b0;
    #2;
    checks++;
    if ({fftready, replicaready, outvalid, outlast, done, err} !== 6'b0 ||
        outdata !== '0 || repl_idx !== '0) begin
      errors++;
      $display("FAIL reset_values: frdy=%b rrdy=%b vld=%b last=%b done=%b err=%b data=%h idx=%0d required all 0",
               fftready, replicaready, outvalid, outlast, done, err, outdata, repl_idx);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (fftready !== 1'b1 || replicaready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: fftready=%b replicaready=%b required 1 0", fftready, replicaready);
    end
  endtask

  task automatic test_full_frame();
    send_frame(32'h0000_0000, 64, 63, -1, 1'b0);
    replay(32'h0000_0000, 64, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    send_frame(32'h0000_1000, 64, 63, -1, 1'b0);
    replay(32'h0000_1000, 64, 1'b1, -1);
  endtask

  task automatic test_convstart_ignored();
    convstart = 1'b1;
    @(posedge clk); #1;
    convstart = 1'b0;
    checks++;
    if (outvalid !== 1'b0 || replicaready !== 1'b0 || fftready !== 1'b1) begin
      errors++;
      $display("FAIL convstart_idle: outvalid=%b replicaready=%b fftready=%b required 0 0 1",
               outvalid, replicaready, fftready);
    end
    send_frame(32'h0000_2000, 64, 63, 5, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (outvalid !== 1'b0 || replicaready !== 1'b1) begin
      errors++;
      $display("FAIL convstart_fill: outvalid=%b replicaready=%b required 0 1", outvalid, replicaready);
    end
    replay(32'h0000_2000, 64, 1'b0, -1);
  endtask

  task automatic test_short_frame();
    // convstart coincides with the final beat and must be ignored.
    send_frame(32'h0000_3000, 16, 15, 15, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (outvalid !== 1'b0) begin
      errors++;
      $display("FAIL convstart_same_cycle: outvalid=%b required 0", outvalid);
    end
    replay(32'h0000_3000, 16, 1'b0, -1);
  endtask

  task automatic test_missing_last();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_by_rst: err=%b required 0", err);
    end
    send_frame(32'h0000_4000, 64, -1, -1, 1'b1);
    fftvalid = 1'b1;
    fftdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (fftready !== 1'b0 || replicaready !== 1'b1) begin
        errors++;
        $display("FAIL extra_beat %0d: fftready=%b replicaready=%b required 0 1", i, fftready, replicaready);
      end
    end
    fftvalid = 1'b0;
    fftdata  = '0;
    replay(32'h0000_4000, 64, 1'b0, -1);
  endtask

  task automatic test_reset_mid_replay();
    send_frame(32'h0000_5000, 64, 63, -1, 1'b1);
    replay(32'h0000_5000, 64, 1'b0, 200);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(32'h0000_6000, 64, 63, -1, 1'b0);
    replay(32'h0000_6000, 64, 1'b0, -1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_after_reset_frame: err=%b required 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_convstart_ignored();
    test_short_frame();
    test_missing_last();
    test_reset_mid_replay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_replica_buf.md
Name: fft_replica_buf

Overview:
Buffers one FFT output frame and replays it REPL times to the frequency-domain conv engine. Sits between the FFT core and the conv datapath. Asserts replicaready to control_conv once the frame is stored. Starts replay on convstart from control_conv.

Parameters:
DW, 32, sample width (complex 16b re + 16b im, re in upper half)
DEPTH, 64, max samples per FFT frame; AW = $clog2(DEPTH)
REPL, 8, number of replays per frame (>=1); RW = $clog2(REPL), min 1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
fftvalid  in  1  FFT output sample valid
fftdata  in  DW  FFT output sample
fftlast  in  1  last sample of FFT frame
fftready  out  1  block accepts FFT samples
replicaready  out  1  frame stored, replay may start (level)
convstart  in  1  start replay; sampled only in READY
outvalid  out  1  replay sample valid to conv engine
outdata  out  DW  replay sample
outlast  out  1  final sample of final replica
outready  in  1  conv engine accepts sample
repl_idx  out  RW  replica number of current outdata
done  out  1  one-cycle pulse after final replay transfer
err  out  1  sticky frame-length error; cleared only by rst

Behaviour:
- Reset (async, active-high): state IDLE; all counters 0; fftready=0, replicaready=0, outvalid=0, outdata=0, outlast=0, repl_idx=0, done=0, err=0. Buffer RAM contents are not cleared.
- Storage: DEPTH x DW RAM with synchronous write. Read path is registered into outdata.
- States: IDLE, FILL, READY, REPLAY, DONE.
- IDLE: fftready=1. An accepted beat (fftvalid&&fftready) writes addr 0 and goes to FILL. If that beat also has fftlast, go to READY with len=1.
- FILL: fftready=1. Each accepted beat writes mem[wr_cnt] and increments wr_cnt.
  - fftlast on an accepted beat: len = wr_cnt+1; go to READY.
  - Beat DEPTH-1 accepted without fftlast: len = DEPTH, set err, go to READY.
  - fftlast with wr_cnt+1 != DEPTH: len = wr_cnt+1, set err (short frame), go to READY.
- READY: fftready=0; replicaready=1 from the cycle after the last write. convstart=1 goes to REPLAY with rd_addr=0 and repl_idx=0.
- REPLAY:
  - outvalid rises the cycle after convstart is sampled, with outdata=mem[0].
  - A transfer occurs when outvalid&&outready.
  - After each transfer, the next sample is presented the next cycle (1 sample/cycle at full outready).
  - When rd_addr wraps at len-1, repl_idx increments.
  - outlast=1 only with sample len-1 of replica REPL-1.
  - While outvalid&&!outready, outdata, outlast and repl_idx hold stable.
  - replicaready stays 1 through REPLAY.
- DONE: entered the cycle after the outlast transfer. outvalid=0, replicaready=0, done=1 for exactly one cycle, then IDLE with counters cleared.
- Latency: last FFT write to replicaready = 1 cycle. convstart to first outvalid = 1 cycle. Minimum REPLAY duration = REPL*len cycles.
- Ignored inputs:
  - fftvalid in READY/REPLAY/DONE (fftready=0, no write).
  - convstart outside READY.
  - outready when outvalid=0.
- Simultaneous events: convstart in the same cycle the frame completes is ignored; convstart is honoured from READY onward only.
- rst mid-frame or mid-replay aborts immediately to IDLE with outputs at reset values. The partial frame is discarded (no replicaready).

Test Plan:
- Frame of 64 samples (data=index), fftlast on beat 63, convstart, outready=1 -> replicaready 1 cycle after beat 63; 512 beats sequence 0..63 repeated 8x; repl_idx steps 0..7; outlast on beat 511 only; done pulses 1 cycle later; err=0.
- Same frame with outready toggling 1/0 each cycle -> outdata/repl_idx stable while stalled; 512 transfers total; order unchanged.
- Short frame: fftlast on beat 15 -> err=1; replay of 16x8=128 beats; outlast on beat 127.
- No fftlast for 64 beats -> err=1, len=64, READY entered; fftready=0 afterwards; extra fftvalid beats not written.
- convstart pulsed in IDLE and during FILL -> no outvalid. convstart in READY -> outvalid next cycle.
- rst asserted mid-REPLAY at beat 200 -> outputs zero asynchronously. New 64-beat frame after release replays correctly with err=0.
